hms_time_counter: RTL

Time-of-day keeper for the digital clock, directly downstream of the 1 Hz tick generator. Consumes the one-cycle-per-second pulse and maintains hours:minutes:seconds in packed BCD (24-hour format). Provides a run/set mode FSM driven by two debounced push-button levels, and feeds the seven-segment display multiplexer.

---
 rtl/hms_time_counter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hms_time_counter.sv
// hms_time_counter: 24-hour time-of-day keeper in packed BCD, with a run/set mode FSM.
// Latency: all outputs are registered and update on the clk edge that samples tick or a button edge.
// Backpressure: none; tick and button edges are consumed in the cycle they occur and nothing stalls.
// Ports: clk, clr (async active-high), tick (1 Hz one-cycle pulse), mode_btn / inc_btn
//   (debounced levels), hour_bcd / min_bcd / sec_bcd (packed BCD time),
//   mode (0=RUN, 1=SET_HOUR, 2=SET_MIN), day_carry (pulse on 23:59:59 -> 00:00:00).
// Optional macro HMS_ALARM_EN adds alarm_hour_bcd / alarm_min_bcd inputs and the alarm output.
module hms_time_counter #(
  parameter int START_HOUR = 0,
  parameter int START_MIN  = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
`ifdef HMS_ALARM_EN
  input  logic [7:0] alarm_hour_bcd,
  input  logic [7:0] alarm_min_bcd,
  output logic       alarm,
`endif
  output logic       day_carry
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam logic [7:0] RST_HOUR = {4'(START_HOUR / 10), 4'(START_HOUR % 10)};
  localparam logic [7:0] RST_MIN  = {4'(START_MIN / 10), 4'(START_MIN % 10)};

  // Increment a packed-BCD field; bit 8 flags the wrap from 'last' back to 00.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      bcd_inc = {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)
      bcd_inc = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  mode_t      state, state_nxt;
  logic       mode_q, inc_q;
  logic       mode_edge, inc_edge;
  logic [8:0] sec_inc, min_inc, hour_inc;
  logic [7:0] hour_nxt, min_nxt, sec_nxt;
  logic       day_nxt;

  assign mode_edge = mode_btn & ~mode_q;
  assign inc_edge  = inc_btn & ~inc_q;

  assign sec_inc  = bcd_inc(sec_bcd, 8'h59);
  assign min_inc  = bcd_inc(min_bcd, 8'h59);
  assign hour_inc = bcd_inc(hour_bcd, 8'h23);

  assign mode = state;

  // Tick and inc are judged against the current state; the mode edge only picks
  // the next state, so a tick or inc coinciding with a mode edge still lands.
  always_comb begin
    state_nxt = state;
    hour_nxt  = hour_bcd;
    min_nxt   = min_bcd;
    sec_nxt   = sec_bcd;
    day_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (tick) begin
          sec_nxt = sec_inc[7:0];
          if (sec_inc[8]) begin
            min_nxt = min_inc[7:0];
            if (min_inc[8]) begin
              hour_nxt = hour_inc[7:0];
              day_nxt  = hour_inc[8];
            end
          end
        end
        if (mode_edge) state_nxt = SET_HOUR;
      end
      SET_HOUR: begin
        if (inc_edge) hour_nxt = hour_inc[7:0];
        if (mode_edge) state_nxt = SET_MIN;
      end
      SET_MIN: begin
        if (inc_edge) min_nxt = min_inc[7:0];
        if (mode_edge) begin
          state_nxt = RUN;
          sec_nxt   = 8'h00;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= RUN;
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      hour_bcd  <= RST_HOUR;
      min_bcd   <= RST_MIN;
      sec_bcd   <= 8'h00;
      day_carry <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_btn;
      inc_q     <= inc_btn;
      hour_bcd  <= hour_nxt;
      min_bcd   <= min_nxt;
      sec_bcd   <= sec_nxt;
      day_carry <= day_nxt;
    end
  end

`ifdef HMS_ALARM_EN
  logic [5:0] alarm_cnt;
  logic       alarm_hit;

  // Only a running tick can land exactly on hh:mm:00; set-mode edits never trigger.
  assign alarm_hit = (state == RUN) && tick && (hour_nxt == alarm_hour_bcd) &&
                     (min_nxt == alarm_min_bcd) && (sec_nxt == 8'h00);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      alarm     <= 1'b0;
      alarm_cnt <= 6'd0;
    end else if (mode_edge || ((state == RUN) && inc_edge)) begin
      alarm <= 1'b0;
    end else if (alarm_hit) begin
      alarm     <= 1'b1;
      alarm_cnt <= 6'd0;
    end else if (alarm && (state == RUN) && tick) begin
      // Self-clear on the 60th tick after the one that raised it.
      if (alarm_cnt == 6'd59) alarm <= 1'b0;
      alarm_cnt <= alarm_cnt + 6'd1;
    end
  end
`else
  // No alarm state in this build.
`endif

endmodule
